// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mul_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } mul_state_t;

  // Unsigned magnitude of a value that may be two's complement; |min| wraps to itself,
  // which read as unsigned is exactly the right magnitude.
  function automatic logic [XLEN-1:0] magnitude(logic [XLEN-1:0] v, logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/shift_expander.sv
// Zero-extends an operand to double width and shifts it left by the given bit index.
module shift_expander #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]   input_a,
  input  logic [6:0]        shift_index,
  output logic [2*XLEN-1:0] output_b
);

  assign output_b = {{XLEN{1'b0}}, input_a} << shift_index;

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative 32x32->64 multiplier (MUL/MULH/MULHSU/MULHU): one partial product per cycle on
// operand magnitudes, followed by a single two's-complement fix-up of the accumulated product.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned IdxW = $clog2(XLEN);

  mul_state_t        state, state_next;
  mul_op_t           op_reg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              neg;
  logic [2*XLEN-1:0] acc;
  logic [IdxW-1:0]   idx;
  logic [2*XLEN-1:0] shifted;
  logic              a_signed, b_signed;

  // MUL only needs the low word, which is signedness-agnostic, so it runs unsigned.
  assign a_signed = (op == MULH) || (op == MULHSU);
  assign b_signed = (op == MULH);

  shift_expander #(
    .XLEN(XLEN)
  ) u_shift_expander (
    .input_a    (mag_a),
    .shift_index({2'b00, idx}),
    .output_b   (shifted)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; requests outside IDLE are ignored
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN:  if (idx == IdxW'(XLEN - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from registered state and accumulator only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    result    = '0;
    if (state == DONE) begin
      result = (op_reg == MUL) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
    end
  end

  // Operand capture, shift-add accumulation and sign fix-up
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg <= MUL;
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      idx    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_reg <= mul_op_t'(op);
            mag_a  <= magnitude(operand_a, a_signed);
            mag_b  <= magnitude(operand_b, b_signed);
            neg    <= (a_signed & operand_a[XLEN-1]) ^ (b_signed & operand_b[XLEN-1]);
            acc    <= '0;
            idx    <= '0;
          end
        end
        RUN: begin
          if (mag_b[idx]) acc <= acc + shifted;
          idx <= idx + 1'b1;
        end
        FIX: begin
          if (neg) acc <= ~acc + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
